// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline-stage registers.
// Holds the skid-buffer state encoding and its depth.
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/pipe_skid_perf.sv
// Saturating stall / flush-kill counter pair for a skid stage.
// i_stall: +1 per cycle; i_flush: +i_occupancy; o_*_cnt: counts.
module pipe_skid_perf #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [1:0]       i_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W:0]   flush_sum;
  logic [CNT_W-1:0] flush_d;

  // One extra bit catches the carry so the add saturates.
  assign flush_sum = {1'b0, flush_q}
                   + {{(CNT_W-1){1'b0}}, i_occupancy};
  assign flush_d   = flush_sum[CNT_W] ? '1
                   : flush_sum[CNT_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (i_stall && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (i_flush)
        flush_q <= flush_d;
    end
  end

  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer.
// Ports: i_valid/o_ready/i_data/i_ctrl upstream, o_valid/i_ready/
// o_data/o_ctrl downstream, i_flush kill, o_occupancy, perf counts.
// PIPE_SKID_PERF_EN adds o_stall_cnt/o_flush_cnt, else tied to 0.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  skid_state_e       state_q;
  skid_state_e       state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;

  // Ready comes only from the state flop: no i_ready -> o_ready path.
  assign o_ready  = (state_q != SKID_TWO);
  assign o_valid  = (state_q == SKID_ONE)
                  | (state_q == SKID_TWO);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  assign o_data = main_data_q;
  assign o_ctrl = main_ctrl_q & {CTRL_W{o_valid}};

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d    = SKID_ONE;
          ld_main_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_d = SKID_TWO;
          ld_skid = 1'b1;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_fire) begin
          state_d      = SKID_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush wins: incoming entry is dropped, payloads keep old data.
    if (i_flush) begin
      state_d      = SKID_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= SKID_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_in) begin
        main_data_q <= i_data;
        main_ctrl_q <= i_ctrl;
      end else if (ld_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (ld_skid) begin
        skid_data_q <= i_data;
        skid_ctrl_q <= i_ctrl;
      end
      if (i_flush) begin
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
      end
    end
  end

  always_comb begin
    o_occupancy = 2'd0;
    case (state_q)
      SKID_ONE: o_occupancy = 2'd1;
      SKID_TWO: o_occupancy = 2'd2;
      default:  o_occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_SKID_PERF_EN
  pipe_skid_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_stall     (o_valid & ~i_ready),
    .i_flush     (i_flush),
    .i_occupancy (o_occupancy),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage.
// Inputs change and outputs are sampled mid low-phase.
module tb_pipe_skid_stage;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int NW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occupancy;
  logic [NW-1:0] o_stall_cnt;
  logic [NW-1:0] o_flush_cnt;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;

  pipe_skid_stage #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_ctrl      (i_ctrl),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_ctrl      (o_ctrl),
    .o_occupancy (o_occupancy),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; score the handshakes that fire on the next edge.
  task automatic step(input logic          v,
                      input logic [DW-1:0] d,
                      input logic [CW-1:0] c,
                      input logic          r,
                      input logic          f,
                      input logic          rn = 1'b1);
    ent_t e;
    i_reset_n = rn;
    i_valid   = v;
    i_data    = d;
    i_ctrl    = c;
    i_ready   = r;
    i_flush   = f;
    #1;
    if (!rn) begin
      q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {127'd0, o_valid}, 128'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", o_data, e.d);
          chk("out_ctrl", o_ctrl, e.c);
        end
      end
      if (f) q.delete();
      else if (v && o_ready) begin
        e.d = d;
        e.c = c;
        q.push_back(e);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_ctrl"}, o_ctrl, 0);
    chk({tag, "_occ"}, o_occupancy, 0);
    chk({tag, "_stall"}, o_stall_cnt, 0);
    chk({tag, "_flcnt"}, o_flush_cnt, 0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    i_ctrl    = '0;
    i_ready   = 1'b0;
    i_flush   = 1'b0;
    @(negedge i_clk);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_reset_outs("rst");

    // Streaming at full rate.
    for (int i = 1; i <= 5; i++) begin
      step(1, DW'(i), 8'h01, 1, 0);
      chk("strm_valid", o_valid, 1);
      chk("strm_occ", o_occupancy, 1);
      chk("strm_ready", o_ready, 1);
      chk("strm_data", o_data, i);
    end
    step(0, 0, 0, 1, 0);
    chk("strm_end_valid", o_valid, 0);

    // Backpressure fill then drain.
    step(1, 96'hA, 8'h02, 0, 0);
    chk("bp_occ1", o_occupancy, 1);
    chk("bp_dataA", o_data, 96'hA);
    step(1, 96'hB, 8'h03, 0, 0);
    chk("bp_occ2", o_occupancy, 2);
    chk("bp_ready0", o_ready, 0);
    chk("bp_hold", o_data, 96'hA);
    step(1, 96'hEE, 8'h04, 0, 0);
    chk("bp_stable_d", o_data, 96'hA);
    chk("bp_stable_c", o_ctrl, 8'h02);
    step(0, 0, 0, 1, 0);
    chk("bp_ready1", o_ready, 1);
    chk("bp_dataB", o_data, 96'hB);
    step(0, 0, 0, 1, 0);
    chk("bp_occ0", o_occupancy, 0);

    // Flush with two entries held and a new one offered.
    step(1, 96'hA, 8'h11, 0, 0);
    step(1, 96'hB, 8'h12, 0, 0);
    step(1, 96'hC, 8'h13, 0, 1);
    chk("fl_valid", o_valid, 0);
    chk("fl_ctrl", o_ctrl, 0);
    chk("fl_occ", o_occupancy, 0);
    chk("fl_ready", o_ready, 1);
`ifdef PIPE_SKID_PERF_EN
    chk("fl_cnt", o_flush_cnt, 2);
`else
    chk("fl_cnt", o_flush_cnt, 0);
`endif
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Control masked once the entry is drained.
    step(1, 96'h77, 8'hFF, 1, 0);
    chk("mask_ctrl_v", o_ctrl, 8'hFF);
    step(0, 0, 0, 1, 0);
    chk("mask_valid", o_valid, 0);
    chk("mask_ctrl", o_ctrl, 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom},
           8'($urandom_range(1, 255)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
      chk("rnd_occ", o_occupancy, q.size());
      chk("rnd_ready", o_ready, q.size() != 2);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    // Reset with two entries held.
    step(1, 96'h1, 8'h21, 0, 0);
    step(1, 96'h2, 8'h22, 0, 0);
    chk("mr_occ2", o_occupancy, 2);
    step(0, 0, 0, 0, 0, 0);
    chk_reset_outs("mr");
    step(1, 96'hD, 8'h31, 0, 0);
    chk("mr_lat_valid", o_valid, 1);
    chk("mr_lat_data", o_data, 96'hD);

    // Long stall on one entry.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
`ifdef PIPE_SKID_PERF_EN
    chk("stall_sat", o_stall_cnt, 4'hF);
`else
    chk("stall_sat", o_stall_cnt, 0);
`endif
    chk("stall_data", o_data, 96'hD);
    step(0, 0, 0, 1, 0);
    chk("end_occ", o_occupancy, 0);
    chk("end_q", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register.
- Generalises the fixed stall/flush inter-stage latches (IF/ID … MEM/WB) to a valid/ready handshake with a 2-entry skid buffer.
- Full throughput, no combinational path from i_ready to o_ready, flush with priority.
- Instantiated between any two stages of the pipelined core; payload and control widths are set per stage.

Parameters:
- DATA_W, 96, payload width (pc, alu result, imm, rd …); never cleared by flush.
- CTRL_W, 8, control-bit width (regwrite, wb_sel, is_ctrl, mispred …); cleared by flush, masked when invalid.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept this cycle
- i_data  in  DATA_W  upstream payload
- i_ctrl  in  CTRL_W  upstream control bits
- i_flush  in  1  kill all held entries and drop incoming
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head
- o_data  out  DATA_W  head payload
- o_ctrl  out  CTRL_W  head control, zero when o_valid=0
- o_occupancy  out  2  entries held (0..2)
- o_stall_cnt  out  CNT_W  cycles with o_valid & !i_ready
- o_flush_cnt  out  CNT_W  valid entries killed by flush

Behaviour:
- Reset: i_reset_n, synchronous, active-low; clock i_clk. On reset: state=EMPTY, main/skid data=0, ctrl=0, counters=0. Outputs: o_valid=0, o_ready=1, o_data=0, o_ctrl=0, o_occupancy=0. Reset mid-transfer discards both entries.
- Handshakes: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- o_ready = (state != TWO); decoded from the state register only.
- o_valid = (state != EMPTY). o_data/o_ctrl are driven from the main register. o_ctrl = main_ctrl & {CTRL_W{o_valid}}.
- State transitions:
  - EMPTY: in_fire -> ONE (main<=in).
  - ONE: in_fire & out_fire -> ONE (main<=in). in_fire only -> TWO (skid<=in). out_fire only -> EMPTY. Neither -> hold.
  - TWO: out_fire -> ONE (main<=skid). Else hold. No in_fire is possible.
- Latency: 1 cycle from in_fire to o_valid. Sustained 1 entry/cycle while i_ready=1.
- Ordering: strict FIFO; skid content is never emitted before main.
- Flush, highest priority after reset: next state=EMPTY, main_ctrl=0, skid_ctrl=0, data retained. A same-cycle in_fire is dropped. A same-cycle out_fire still counts downstream, since head is visible combinationally. Next cycle o_ready=1.
- Stall: i_ready=0 holds the head stable. o_data/o_ctrl must not change while o_valid & !i_ready.
- o_occupancy: EMPTY=0, ONE=1, TWO=2.
- The illegal state encoding (2'b11) recovers to EMPTY.

Optional Feature:
- Macro PIPE_SKID_PERF_EN.
- Defined: o_stall_cnt increments each cycle with o_valid & !i_ready. o_flush_cnt adds the occupancy (0/1/2) on each cycle i_flush=1. Both saturate at all-ones and are cleared only by reset.
- Undefined: no counter flops; both ports tied to 0. Port list unchanged.

Decomposition:
- pipe_pkg holds:
  - typedef enum logic [1:0] skid_state_e {SKID_EMPTY=2'd0, SKID_ONE=2'd1, SKID_TWO=2'd2};
  - localparam SKID_DEPTH=2.
- One sub-module: pipe_skid_perf (saturating counter pair, CNT_W parameter), instantiated only under PIPE_SKID_PERF_EN.

Test Plan:
- Streaming: i_ready=1, push 5 entries with data 1..5, ctrl 8'h01 on back-to-back cycles -> o_valid one cycle after each push; outputs 1..5 in order; o_ready stays 1; occupancy stays 1.
- Backpressure fill: i_ready=0, push A=32'hA, B=32'hB -> occupancy 1 then 2; o_ready=0 in the cycle after B; o_data=A stable. Raise i_ready -> A, then B; o_ready=1 one cycle after A is taken.
- Flush in TWO: hold A,B, assert i_flush with i_valid=1 (C) -> next cycle o_valid=0, o_ctrl=0, occupancy 0, o_ready=1; C never appears. With PIPE_SKID_PERF_EN, o_flush_cnt=2.
- Invalid masking: entry with ctrl 8'hFF accepted, drained, no new input -> o_ctrl=0 while o_valid=0, though the register still holds 8'hFF.
- Reset mid-operation: occupancy 2, assert i_reset_n=0 for 1 cycle -> all outputs at reset values; counters 0; subsequent push with latency 1.
- Stall counter: PIPE_SKID_PERF_EN with CNT_W=4, hold one entry with i_ready=0 for 20 cycles -> o_stall_cnt saturates at 4'hF.
